// File: rtl/jelly3_axi4l_bram_banked_pkg.sv
// Shared types for the banked BRAM AXI4-Lite accessor: controller states and
// AXI response codes.
package jelly3_axi4l_bram_banked_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    BRESP,
    RRESP
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/jelly3_bram_en_pipeline.sv
// Per-bank read-enable shift register: stage 0 is passed straight through,
// later stages follow a read start by one cycle each, all gated by cke.
module jelly3_bram_en_pipeline #(
  parameter int BANKS    = 4,
  parameter int RLATENCY = 2
) (
  input  logic                            reset,
  input  logic                            clk,
  input  logic                            cke,
  input  logic [BANKS-1:0]                en_first,
  input  logic [BANKS-1:0]                en_follow,
  output logic [BANKS-1:0][RLATENCY-1:0]  m_en
);

  if (RLATENCY > 1) begin : g_stages
    logic [BANKS-1:0][RLATENCY-1:1] stage;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage <= '0;
      end else if (cke) begin
        for (int unsigned b = 0; b < BANKS; b++) begin
          stage[b][1] <= en_follow[b];
          for (int unsigned k = 2; k < RLATENCY; k++) begin
            stage[b][k] <= stage[b][k-1];
          end
        end
      end
    end

    always_comb begin
      m_en = '0;
      for (int unsigned b = 0; b < BANKS; b++) begin
        m_en[b] = cke ? {stage[b], en_first[b]} : '0;
      end
    end
  end else begin : g_single
    logic unused_follow;
    assign unused_follow = ^en_follow;

    always_comb begin
      m_en = '0;
      for (int unsigned b = 0; b < BANKS; b++) begin
        m_en[b][0] = cke & en_first[b];
      end
    end
  end

endmodule

// File: rtl/jelly3_axi4l_bram_banked_accessor.sv
// AXI4-Lite slave giving single-outstanding access to a set of BRAM banks
// with configurable write/read latency and round-robin read/write arbitration.
module jelly3_axi4l_bram_banked_accessor
  import jelly3_axi4l_bram_banked_pkg::*;
#(
  parameter int BANKS          = 4,
  parameter int BANK_ADDR_BITS = 10,
  parameter int DATA_BITS      = 32,
  parameter int BYTE_BITS      = 8,
  parameter int WE_BITS        = DATA_BITS / BYTE_BITS,
  parameter int WLATENCY       = 1,
  parameter int RLATENCY       = 2,
  parameter int AXI_ADDR_BITS  = BANK_ADDR_BITS + $clog2(BANKS) + $clog2(WE_BITS)
) (
  input  logic                                reset,
  input  logic                                clk,
  input  logic                                cke,
  input  logic [AXI_ADDR_BITS-1:0]            s_axi4l_awaddr,
  input  logic                                s_axi4l_awvalid,
  output logic                                s_axi4l_awready,
  input  logic [DATA_BITS-1:0]                s_axi4l_wdata,
  input  logic [WE_BITS-1:0]                  s_axi4l_wstrb,
  input  logic                                s_axi4l_wvalid,
  output logic                                s_axi4l_wready,
  output logic [1:0]                          s_axi4l_bresp,
  output logic                                s_axi4l_bvalid,
  input  logic                                s_axi4l_bready,
  input  logic [AXI_ADDR_BITS-1:0]            s_axi4l_araddr,
  input  logic                                s_axi4l_arvalid,
  output logic                                s_axi4l_arready,
  output logic [DATA_BITS-1:0]                s_axi4l_rdata,
  output logic [1:0]                          s_axi4l_rresp,
  output logic                                s_axi4l_rvalid,
  input  logic                                s_axi4l_rready,
  output logic [BANKS-1:0][RLATENCY-1:0]      m_en,
  output logic [BANKS-1:0][WE_BITS-1:0]       m_we,
  output logic [BANK_ADDR_BITS-1:0]           m_addr,
  output logic [DATA_BITS-1:0]                m_wdata,
  input  logic [BANKS-1:0][DATA_BITS-1:0]     m_rdata
);

  localparam int WORD_SHIFT = $clog2(WE_BITS);
  localparam int MAX_LAT    = (WLATENCY > RLATENCY) ? WLATENCY : RLATENCY;
  localparam int CNT_BITS   = $clog2(MAX_LAT + 1);

  state_t                 state;
  logic [CNT_BITS-1:0]    cnt;
  logic                   prio_write;
  logic                   err;
  logic [BANKS-1:0]       rsel;

  logic [AXI_ADDR_BITS-1:0] wword, rword;
  logic [BANKS-1:0]       wbank, rbank;
  logic                   idle, wreq, rreq, wacc, racc;
  logic [BANKS-1:0]       en_first, en_follow;
  logic [DATA_BITS-1:0]   rmux;

  // One-hot bank decode; an out-of-range bank decodes to all zeros.
  always_comb begin
    wword = s_axi4l_awaddr >> WORD_SHIFT;
    rword = s_axi4l_araddr >> WORD_SHIFT;
    wbank = '0;
    rbank = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      wbank[b] = ((wword >> BANK_ADDR_BITS) == AXI_ADDR_BITS'(b));
      rbank[b] = ((rword >> BANK_ADDR_BITS) == AXI_ADDR_BITS'(b));
    end
  end

  assign idle = !reset && cke && (state == IDLE);
  assign wreq = s_axi4l_awvalid && s_axi4l_wvalid;
  assign rreq = s_axi4l_arvalid;
  assign wacc = idle && wreq && (!rreq || prio_write);
  assign racc = idle && rreq && (!wreq || !prio_write);

  assign s_axi4l_awready = wacc;
  assign s_axi4l_wready  = wacc;
  assign s_axi4l_arready = racc;

  always_comb begin
    m_addr    = '0;
    m_wdata   = '0;
    m_we      = '0;
    en_first  = '0;
    en_follow = '0;
    if (wacc) begin
      m_addr  = wword[BANK_ADDR_BITS-1:0];
      m_wdata = s_axi4l_wdata;
    end else if (racc) begin
      m_addr  = rword[BANK_ADDR_BITS-1:0];
    end
    for (int unsigned b = 0; b < BANKS; b++) begin
      m_we[b]      = (wacc && wbank[b]) ? s_axi4l_wstrb : '0;
      en_first[b]  = (wacc && wbank[b]) || (racc && rbank[b]);
      en_follow[b] = racc && rbank[b];
    end
  end

  always_comb begin
    rmux = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      if (rsel[b]) rmux |= m_rdata[b];
    end
  end

  jelly3_bram_en_pipeline #(
    .BANKS    (BANKS),
    .RLATENCY (RLATENCY)
  ) u_en_pipeline (
    .reset     (reset),
    .clk       (clk),
    .cke       (cke),
    .en_first  (en_first),
    .en_follow (en_follow),
    .m_en      (m_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      prio_write     <= 1'b1;
      err            <= 1'b0;
      rsel           <= '0;
      s_axi4l_bvalid <= 1'b0;
      s_axi4l_bresp  <= OKAY;
      s_axi4l_rvalid <= 1'b0;
      s_axi4l_rresp  <= OKAY;
      s_axi4l_rdata  <= '0;
    end else if (cke) begin
      case (state)
        IDLE: begin
          // Only a genuine conflict moves the round-robin pointer.
          if (wreq && rreq) prio_write <= !prio_write;
          if (wacc) begin
            state <= WRITE;
            cnt   <= CNT_BITS'(WLATENCY - 1);
            err   <= ~|wbank;
          end else if (racc) begin
            state <= READ;
            cnt   <= CNT_BITS'(RLATENCY - 1);
            err   <= ~|rbank;
            rsel  <= rbank;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            state          <= BRESP;
            s_axi4l_bvalid <= 1'b1;
            s_axi4l_bresp  <= err ? SLVERR : OKAY;
          end else begin
            cnt <= cnt - CNT_BITS'(1);
          end
        end
        READ: begin
          if (cnt == '0) begin
            state          <= RRESP;
            s_axi4l_rvalid <= 1'b1;
            s_axi4l_rresp  <= err ? SLVERR : OKAY;
            s_axi4l_rdata  <= rmux;
          end else begin
            cnt <= cnt - CNT_BITS'(1);
          end
        end
        BRESP: begin
          if (s_axi4l_bready) begin
            s_axi4l_bvalid <= 1'b0;
            state          <= IDLE;
          end
        end
        RRESP: begin
          if (s_axi4l_rready) begin
            s_axi4l_rvalid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jelly3_axi4l_bram_banked_accessor.sv
// Randomized bench for the banked BRAM accessor: a word-level reference memory
// and transaction-age model predict every DUT output each cycle.
module tb_jelly3_axi4l_bram_banked_accessor;

  localparam int BANKS = 3;
  localparam int BA    = 10;
  localparam int DB    = 32;
  localparam int WEB   = 4;
  localparam int WL    = 2;
  localparam int RL    = 3;
  localparam int AAB   = BA + 2 + 2;

  logic clk = 1'b0, reset = 1'b1, cke = 1'b1;
  logic [AAB-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic [DB-1:0] wdata = '0;
  logic [WEB-1:0] wstrb = '0;
  logic awready, wready, arready, bvalid, rvalid;
  logic [1:0] bresp, rresp;
  logic [DB-1:0] rdata;
  logic [BANKS-1:0][RL-1:0] m_en;
  logic [BANKS-1:0][WEB-1:0] m_we;
  logic [BA-1:0] m_addr;
  logic [DB-1:0] m_wdata;
  logic [BANKS-1:0][DB-1:0] m_rdata;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  jelly3_axi4l_bram_banked_accessor #(
    .BANKS(BANKS), .BANK_ADDR_BITS(BA), .DATA_BITS(DB), .BYTE_BITS(8),
    .WLATENCY(WL), .RLATENCY(RL)
  ) dut (
    .reset(reset), .clk(clk), .cke(cke),
    .s_axi4l_awaddr(awaddr), .s_axi4l_awvalid(awvalid), .s_axi4l_awready(awready),
    .s_axi4l_wdata(wdata), .s_axi4l_wstrb(wstrb), .s_axi4l_wvalid(wvalid), .s_axi4l_wready(wready),
    .s_axi4l_bresp(bresp), .s_axi4l_bvalid(bvalid), .s_axi4l_bready(bready),
    .s_axi4l_araddr(araddr), .s_axi4l_arvalid(arvalid), .s_axi4l_arready(arready),
    .s_axi4l_rdata(rdata), .s_axi4l_rresp(rresp), .s_axi4l_rvalid(rvalid), .s_axi4l_rready(rready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  function automatic logic [DB-1:0] init_val(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  // BRAM banks: stage 0 reads/writes memory, stage k moves the read data on.
  logic [DB-1:0] mem [BANKS][1024];
  logic [DB-1:0] q [BANKS][RL];
  initial begin
    for (int b = 0; b < BANKS; b++) begin
      for (int a = 0; a < 1024; a++) mem[b][a] = init_val(b * 1024 + a);
      for (int k = 0; k < RL; k++) q[b][k] = '0;
    end
  end
  always @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (m_en[b][0]) begin
        for (int i = 0; i < WEB; i++)
          if (m_we[b][i]) mem[b][m_addr][8*i +: 8] <= m_wdata[8*i +: 8];
        q[b][0] <= mem[b][m_addr];
      end
      for (int k = 1; k < RL; k++)
        if (m_en[b][k]) q[b][k] <= q[b][k-1];
    end
  end
  always_comb begin
    m_rdata = '0;
    for (int b = 0; b < BANKS; b++) m_rdata[b] = q[b][RL-1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word-indexed memory plus the age of the single outstanding transaction.
  logic [DB-1:0] ref_mem [int];
  bit  busy = 0, kind_w = 0, prio_w = 1, cur_ok = 0;
  int  age = 0, cur_bank = 0;
  logic [1:0] exp_resp = '0;
  logic [DB-1:0] exp_rdata = '0;

  function automatic logic [DB-1:0] ref_val(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  always @(negedge clk) begin
    logic [BANKS-1:0][RL-1:0] e_en;
    logic [BANKS-1:0][WEB-1:0] e_we;
    logic [BA-1:0] e_addr;
    logic [DB-1:0] e_wdata, v;
    bit aw_req, ar_req, e_aw, e_ar, e_bv, e_rv, conflict;
    int ww, rw, wb, rb;
    if (reset) begin
      chk("rst_ready", {awready, wready, arready}, 0);
      chk("rst_valid", {bvalid, rvalid}, 0);
      chk("rst_resp", {bresp, rresp}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_bram", {m_en, m_we, m_addr, m_wdata}, 0);
      busy = 0; prio_w = 1;
    end else begin
      aw_req = awvalid && wvalid;
      ar_req = arvalid;
      conflict = !busy && aw_req && ar_req;
      e_aw = cke && !busy && aw_req && (!ar_req || prio_w);
      e_ar = cke && !busy && ar_req && (!aw_req || !prio_w);
      ww = int'(awaddr) >> 2; wb = ww >> BA;
      rw = int'(araddr) >> 2; rb = rw >> BA;
      e_bv = busy && kind_w && age >= WL + 1;
      e_rv = busy && !kind_w && age >= RL + 1;
      e_en = '0; e_we = '0; e_addr = '0; e_wdata = '0;
      if (e_aw) begin
        e_addr = BA'(ww % 1024); e_wdata = wdata;
        if (wb < BANKS) begin e_en[wb][0] = 1'b1; e_we[wb] = wstrb; end
      end else if (e_ar) begin
        e_addr = BA'(rw % 1024);
        if (rb < BANKS) e_en[rb][0] = 1'b1;
      end
      if (cke && busy && !kind_w && cur_ok && age < RL) e_en[cur_bank][age] = 1'b1;
      chk("awready", awready, e_aw);
      chk("wready", wready, e_aw);
      chk("arready", arready, e_ar);
      chk("bvalid", bvalid, e_bv);
      chk("rvalid", rvalid, e_rv);
      chk("m_en", m_en, e_en);
      chk("m_we", m_we, e_we);
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wdata);
      if (e_bv) chk("bresp", bresp, exp_resp);
      if (e_rv) begin chk("rresp", rresp, exp_resp); chk("rdata", rdata, exp_rdata); end
      if (cke) begin
        if (busy && ((e_bv && bready) || (e_rv && rready))) busy = 0;
        else if (busy && age < 1000) age++;
        if (conflict) prio_w = !prio_w;
        if (e_aw) begin
          busy = 1; kind_w = 1; age = 1;
          exp_resp = (wb < BANKS) ? 2'b00 : 2'b10;
          if (wb < BANKS) begin
            v = ref_val(ww);
            for (int i = 0; i < WEB; i++) if (wstrb[i]) v[8*i +: 8] = wdata[8*i +: 8];
            ref_mem[ww] = v;
          end
        end
        if (e_ar) begin
          busy = 1; kind_w = 0; age = 1; cur_bank = rb; cur_ok = (rb < BANKS);
          exp_resp = cur_ok ? 2'b00 : 2'b10;
          exp_rdata = cur_ok ? ref_val(rw) : '0;
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1; cke = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit is_b, input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!(is_b ? bvalid : rvalid) && n < limit);
  endtask

  function automatic logic [AAB-1:0] rand_addr();
    int unsigned bank = $urandom_range(0, 3);
    int unsigned w = $urandom_range(0, 7);
    int unsigned by = $urandom_range(0, 3);
    return AAB'((bank << 12) | (w << 2) | by);
  endfunction

  initial begin
    int n, nacc;
    logic [3:0] order;
    logic [1:0] held;

    repeat (3) @(negedge clk);
    chk("reset_m_en", m_en, 0);
    chk("reset_bvalid", bvalid, 0);
    @(posedge clk); #1; reset = 0;
    idle_cycles(2);

    // write 0x1008 -> bank 1, word 2
    awaddr = 14'h1008; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    chk("wr_awready", awready, 1);
    chk("wr_m_en", m_en, 9'h008);
    chk("wr_m_we", m_we, 12'h0F0);
    chk("wr_m_addr", m_addr, 2);
    chk("wr_m_wdata", m_wdata, 32'hDEADBEEF);
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    wait_valid(1, 50, n);
    chk("wr_latency", n, WL + 1);
    chk("wr_bresp", bresp, 2'b00);
    @(posedge clk); #1;

    // read back 0x1008
    araddr = 14'h1008; arvalid = 1; rready = 1;
    @(negedge clk);
    chk("rd_arready", arready, 1);
    chk("rd_m_en", m_en, 9'h008);
    chk("rd_m_we", m_we, 0);
    @(posedge clk); #1; arvalid = 0;
    wait_valid(0, 50, n);
    chk("rd_latency", n, RL + 1);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_rresp", rresp, 2'b00);
    idle_cycles(2);

    // out-of-range bank 3
    araddr = 14'h3000; arvalid = 1;
    @(negedge clk);
    chk("oor_arready", arready, 1);
    chk("oor_m_en", m_en, 0);
    @(posedge clk); #1; arvalid = 0;
    wait_valid(0, 50, n);
    chk("oor_latency", n, RL + 1);
    chk("oor_rresp", rresp, 2'b10);
    chk("oor_rdata", rdata, 0);
    idle_cycles(2);

    // round-robin with both requests held
    awaddr = 14'h0010; araddr = 14'h0010; wdata = 32'h11223344; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; arvalid = 1;
    order = '0; nacc = 0;
    for (int c = 0; c < 100 && nacc < 4; c++) begin
      @(negedge clk);
      if (awready) begin order = {order[2:0], 1'b1}; nacc++; end
      else if (arready) begin order = {order[2:0], 1'b0}; nacc++; end
    end
    @(posedge clk); #1;
    chk("rr_count", nacc, 4);
    chk("rr_order", order, 4'b1010);
    idle_cycles(10);

    // response back-pressure
    awaddr = 14'h2004; wdata = 32'hCAFE0001; wstrb = 4'h3; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    chk("bp_awready", awready, 1);
    @(posedge clk); #1; araddr = 14'h0004; arvalid = 1;
    wait_valid(1, 50, n);
    chk("bp_latency", n, WL + 1);
    held = bresp;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_bvalid", bvalid, 1);
      chk("bp_bresp", bresp, held);
      chk("bp_no_accept", {awready, arready}, 0);
    end
    @(posedge clk); #1; bready = 1;
    @(negedge clk);
    chk("bp_hs_no_accept", {awready, arready}, 0);
    @(posedge clk); #1;
    idle_cycles(3);

    // reset during READ
    araddr = 14'h1008; arvalid = 1;
    @(negedge clk);
    chk("rst_rd_arready", arready, 1);
    @(posedge clk); #1; arvalid = 0;
    @(posedge clk); #1; reset = 1;
    #1;
    chk("rst_mid_valid", {bvalid, rvalid, awready, arready}, 0);
    chk("rst_mid_bram", {m_en, m_we, m_addr, m_wdata}, 0);
    chk("rst_mid_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1; reset = 0;
    for (int c = 0; c < RL + 5; c++) begin
      @(negedge clk);
      chk("rst_no_rvalid", rvalid, 0);
    end

    // randomized traffic with clock-enable gaps and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset   = ($urandom_range(0, 599) == 0);
      cke     = ($urandom_range(0, 7) != 0);
      awvalid = 1'($urandom_range(0, 1));
      wvalid  = ($urandom_range(0, 3) != 0);
      arvalid = 1'($urandom_range(0, 1));
      awaddr  = rand_addr();
      araddr  = rand_addr();
      wdata   = $urandom;
      wstrb   = 4'($urandom_range(0, 15));
      bready  = ($urandom_range(0, 3) != 0);
      rready  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1; reset = 0;
    idle_cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
